// File: rtl/id_operand_issue.sv
// rtl/id_operand_issue.sv - ID operand resolution, hazard detection and ID/EX issue register
//
// Resolves rs1/rs2 from the register file or from NFWD prioritised
// forwarding sources. Index 0 is the youngest source and has the highest
// priority. x0 always reads as zero.
// Stalls on a match against a pending producer, and holds the resolved
// payload in a valid/ready ID/EX register.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kill held and incoming instruction
//   in_valid / in_ready       decoded instruction handshake
//   in_pc, in_imm, in_ctrl    instruction PC, immediate, opaque control
//   in_rs1_*, in_rs2_*        source addresses and read enables
//   in_use_imm                op2 takes imm when rs2 is not read
//   rf_rs1_data, rf_rs2_data  combinational register-file read data
//   fwd_valid/addr/data/pending  packed forwarding sources
//   out_valid / out_ready     ID/EX payload handshake
//   out_pc, out_op1, out_op2, out_ctrl  registered payload
//   stall_o                   IF/ID must hold its instruction
//   stall_cnt                 saturating hazard-stall cycle count
module id_operand_issue #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CTRL_W  = 16,
    parameter int NFWD    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [RADDR_W-1:0]      in_rs1_addr,
    input  logic [RADDR_W-1:0]      in_rs2_addr,
    input  logic                    in_rs1_en,
    input  logic                    in_rs2_en,
    input  logic [XLEN-1:0]         in_imm,
    input  logic                    in_use_imm,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [XLEN-1:0]         rf_rs1_data,
    input  logic [XLEN-1:0]         rf_rs2_data,
    input  logic [NFWD-1:0]         fwd_valid,
    input  logic [NFWD*RADDR_W-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0]    fwd_data,
    input  logic [NFWD-1:0]         fwd_pending,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_op1,
    output logic [XLEN-1:0]         out_op2,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic                    stall_o,
    output logic [CNT_W-1:0]        stall_cnt
);

    // Returns {hazard, value}. The first matching source wins outright:
    // a pending younger match hides any older ready match.
    function automatic logic [XLEN:0] resolve(
        input logic [RADDR_W-1:0]      addr,
        input logic [XLEN-1:0]         rf_data,
        input logic [NFWD-1:0]         fv,
        input logic [NFWD*RADDR_W-1:0] fa,
        input logic [NFWD*XLEN-1:0]    fd,
        input logic [NFWD-1:0]         fp
    );
        logic [XLEN:0] r;
        logic          hit;
        r   = {1'b0, rf_data};
        hit = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            if (!hit && fv[k] && fa[k*RADDR_W +: RADDR_W] == addr) begin
                hit = 1'b1;
                r   = fp[k] ? {1'b1, {XLEN{1'b0}}} : {1'b0, fd[k*XLEN +: XLEN]};
            end
        end
        if (addr == '0) begin
            r = '0;
        end
        return r;
    endfunction

    logic [XLEN:0]   res1;
    logic [XLEN:0]   res2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hazard;
    logic            accept;

    always_comb begin
        res1 = resolve(in_rs1_addr, rf_rs1_data, fwd_valid, fwd_addr, fwd_data, fwd_pending);
        res2 = resolve(in_rs2_addr, rf_rs2_data, fwd_valid, fwd_addr, fwd_data, fwd_pending);
        op1  = in_rs1_en ? res1[XLEN-1:0] : '0;
        if (in_rs2_en) begin
            op2 = res2[XLEN-1:0];
        end else begin
            op2 = in_use_imm ? in_imm : '0;
        end
        hazard = in_valid & ((in_rs1_en & res1[XLEN]) | (in_rs2_en & res2[XLEN]));
    end

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~hazard & ~flush;
    assign stall_o  = ~flush & in_valid & (hazard | ~in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            // A hazard here leaves accept low, which inserts a bubble.
            out_valid <= accept;
            if (accept) begin
                out_pc   <= in_pc;
                out_op1  <= op1;
                out_op2  <= op2;
                out_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_operand_issue.sv
// tb/tb_id_operand_issue.sv - self-checking bench for id_operand_issue
module tb_id_operand_issue;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int CW   = 16;
    localparam int NF   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush, in_valid, in_rs1_en, in_rs2_en, in_use_imm, out_ready;
    logic [XLEN-1:0]  in_pc, in_imm, rf_rs1_data, rf_rs2_data;
    logic [RW-1:0]    in_rs1_addr, in_rs2_addr;
    logic [CW-1:0]    in_ctrl;
    logic [NF-1:0]    fwd_valid, fwd_pending;
    logic [NF*RW-1:0] fwd_addr;
    logic [NF*XLEN-1:0] fwd_data;

    logic             in_ready, out_valid, stall_o;
    logic [XLEN-1:0]  out_pc, out_op1, out_op2;
    logic [CW-1:0]    out_ctrl;
    logic [15:0]      stall_cnt;

    logic             s_in_ready, s_out_valid, s_stall_o;
    logic [XLEN-1:0]  s_out_pc, s_out_op1, s_out_op2;
    logic [CW-1:0]    s_out_ctrl;
    logic [1:0]       s_stall_cnt;

    id_operand_issue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_ctrl(in_ctrl), .rf_rs1_data(rf_rs1_data),
        .rf_rs2_data(rf_rs2_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .fwd_pending(fwd_pending), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
        .out_ctrl(out_ctrl), .stall_o(stall_o), .stall_cnt(stall_cnt)
    );

    id_operand_issue #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_ctrl(in_ctrl), .rf_rs1_data(rf_rs1_data),
        .rf_rs2_data(rf_rs2_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .fwd_pending(fwd_pending), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_pc(s_out_pc), .out_op1(s_out_op1), .out_op2(s_out_op2),
        .out_ctrl(s_out_ctrl), .stall_o(s_stall_o), .stall_cnt(s_stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what EX should be seeing, plus an unbounded stall tally.
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_op1, m_op2;
    logic [CW-1:0]   m_ctrl;
    int              m_stalls;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Operand value from the source rules; bit 32 flags a pending producer.
    function automatic logic [32:0] ref_operand(input logic en, input logic [RW-1:0] addr,
                                                input logic [XLEN-1:0] rf, input bit is_op2);
        if (!en) return {1'b0, (is_op2 && in_use_imm) ? in_imm : 32'd0};
        if (addr == 0) return 33'd0;
        for (int k = 0; k < NF; k++) begin
            if (fwd_valid[k] && fwd_addr[k*RW +: RW] == addr)
                return fwd_pending[k] ? {1'b1, 32'd0} : {1'b0, fwd_data[k*XLEN +: XLEN]};
        end
        return {1'b0, rf};
    endfunction

    task automatic cycle();
        logic [32:0] r1, r2;
        logic haz, rdy, acc, stl;
        #3;
        r1  = ref_operand(in_rs1_en, in_rs1_addr, rf_rs1_data, 1'b0);
        r2  = ref_operand(in_rs2_en, in_rs2_addr, rf_rs2_data, 1'b1);
        haz = in_valid & (r1[32] | r2[32]);
        rdy = ~m_valid | out_ready;
        acc = in_valid & rdy & ~haz & ~flush;
        stl = ~flush & in_valid & (haz | ~rdy);
        check("in_ready", in_ready, rdy);
        check("stall_o", stall_o, stl);
        check("sat_stall_o", {s_in_ready, s_stall_o}, {rdy, stl});
        if (rst) begin
            m_valid = 0; m_pc = 0; m_op1 = 0; m_op2 = 0; m_ctrl = 0; m_stalls = 0;
        end else begin
            if (flush) m_valid = 0;
            else if (rdy) begin
                m_valid = acc;
                if (acc) begin
                    m_pc = in_pc; m_op1 = r1[31:0]; m_op2 = r2[31:0]; m_ctrl = in_ctrl;
                end
            end
            if (haz && !flush) m_stalls++;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("payload", {out_pc, out_op1, out_op2, out_ctrl}, {m_pc, m_op1, m_op2, m_ctrl});
        check("stall_cnt", stall_cnt, (m_stalls > 65535) ? 65535 : m_stalls);
        check("sat_payload", {s_out_valid, s_out_pc, s_out_op1, s_out_op2, s_out_ctrl},
              {m_valid, m_pc, m_op1, m_op2, m_ctrl});
        check("sat_stall_cnt", s_stall_cnt, (m_stalls > 3) ? 3 : m_stalls);
    endtask

    task automatic idle();
        rst = 0; flush = 0; in_valid = 0; in_rs1_en = 0; in_rs2_en = 0; in_use_imm = 0;
        out_ready = 1; in_pc = 0; in_imm = 0; rf_rs1_data = 0; rf_rs2_data = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_ctrl = 0;
        fwd_valid = 0; fwd_pending = 0; fwd_addr = 0; fwd_data = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        m_valid = 0; m_pc = 0; m_op1 = 0; m_op2 = 0; m_ctrl = 0; m_stalls = 0;
        cycle();
        check("reset_valid", out_valid, 1'b0);
        check("reset_cnt", stall_cnt, 16'd0);
        idle();

        // Back-to-back issue, rs1 from RF and op2 from immediate
        in_valid = 1; in_rs1_en = 1; in_rs1_addr = 1; rf_rs1_data = 5;
        in_imm = 7; in_use_imm = 1; in_ctrl = 16'h00A5;
        for (int i = 0; i < 4; i++) begin
            in_pc = 32'h100 + 4 * i;
            cycle();
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_op", {out_pc, out_op1, out_op2}, {32'h100 + 4 * i, 32'd5, 32'd7});
        end
        check("b2b_cnt", stall_cnt, 16'd0);

        // Forwarding priority
        in_rs1_addr = 3; rf_rs1_data = 32'hCC;
        fwd_valid = 2'b11; fwd_addr = {5'd3, 5'd3}; fwd_data = {32'hBB, 32'hAA};
        cycle();
        check("prio_src0", out_op1, 32'hAA);
        fwd_valid = 2'b10;
        cycle();
        check("prio_src1", out_op1, 32'hBB);

        // Load-use: one bubble, then forwarded from the older slot
        in_rs1_en = 0; in_rs2_en = 1; in_rs2_addr = 4; in_use_imm = 0; in_pc = 32'h200;
        fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd4}; fwd_pending = 2'b01;
        cycle();
        check("lu_bubble", out_valid, 1'b0);
        check("lu_cnt", stall_cnt, 16'd1);
        fwd_valid = 2'b10; fwd_addr = {5'd4, 5'd0}; fwd_pending = 2'b00;
        fwd_data = {32'h1234, 32'h0};
        cycle();
        check("lu_fwd", {out_valid, out_op2}, {1'b1, 32'h1234});

        // x0 ignores a pending source
        in_rs2_en = 0; in_rs1_en = 1; in_rs1_addr = 0; rf_rs1_data = 32'hDEAD;
        fwd_valid = 2'b01; fwd_addr = 0; fwd_data = {32'h0, 32'hFF}; fwd_pending = 2'b01;
        cycle();
        check("x0_op1", {out_valid, out_op1}, {1'b1, 32'd0});
        idle();

        // Backpressure holds the payload; release issues the waiting instruction
        in_valid = 1; in_pc = 32'h300; cycle();
        out_ready = 0; in_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold", {out_valid, out_pc}, {1'b1, 32'h300});
        end
        out_ready = 1; cycle();
        check("bp_release", out_pc, 32'h304);

        // Flush kills the held payload
        flush = 1; cycle();
        check("flush_valid", out_valid, 1'b0);
        flush = 0;

        // Saturation and flush-with-hazard
        rst = 1; cycle(); rst = 0;
        in_rs1_en = 1; in_rs1_addr = 9;
        fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd9}; fwd_pending = 2'b01;
        for (int i = 0; i < 5; i++) cycle();
        check("sat_hold", s_stall_cnt, 2'd3);
        check("wide_cnt", stall_cnt, 16'd5);
        flush = 1; cycle();
        check("flush_haz_cnt", stall_cnt, 16'd5);
        flush = 0;
        rst = 1; cycle();
        check("rst_mid_stall", {out_valid, stall_cnt}, {1'b0, 16'd0});
        idle();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            flush       = ($urandom_range(0, 11) == 0);
            in_valid    = ($urandom_range(0, 9) < 8);
            out_ready   = ($urandom_range(0, 9) < 7);
            in_pc       = $urandom; in_imm = $urandom; in_ctrl = 16'($urandom);
            in_rs1_en   = $urandom_range(0, 1); in_rs2_en = $urandom_range(0, 1);
            in_use_imm  = $urandom_range(0, 1);
            in_rs1_addr = 5'($urandom_range(0, 7)); in_rs2_addr = 5'($urandom_range(0, 7));
            rf_rs1_data = $urandom; rf_rs2_data = $urandom;
            fwd_valid   = 2'($urandom);
            fwd_pending = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            fwd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data    = {$urandom, $urandom};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_operand_issue.md
# id_operand_issue

Parametrised operand-resolution and issue stage between IF/ID and ID/EX of the RISC-V pipeline. Takes one decoded instruction per cycle and resolves rs1/rs2 from the register file or from NFWD prioritised forwarding sources, with x0 hard-wired to zero. It detects use-of-pending-result hazards (load-use and longer-latency producers) and inserts bubbles. The result is held in a registered ID/EX payload with valid/ready backpressure, flush, and a saturating hazard-stall counter.

## Interface
- XLEN, 32: data width.
- RADDR_W, 5: register address width.
- CTRL_W, 16: opaque decoded-control payload width (aluop, alusel, rd, rd_enable) passed through unchanged.
- NFWD, 2: number of forwarding sources; index 0 is youngest (EX), highest priority.
- CNT_W, 16: stall counter width.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  branch/jump redirect; kills the held and incoming instruction.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  XLEN  instruction PC.
- in_rs1_addr, in_rs2_addr  in  RADDR_W each  source register addresses, also driven to the register file.
- in_rs1_en, in_rs2_en  in  1 each  source read enables.
- in_imm  in  XLEN  sign-extended immediate.
- in_use_imm  in  1  op2 takes imm when rs2 is not read.
- in_ctrl  in  CTRL_W  decoded control.
- rf_rs1_data, rf_rs2_data  in  XLEN each  register-file read data, combinational.
- fwd_valid  in  NFWD  source k holds a write to fwd_addr[k].
- fwd_addr  in  NFWD*RADDR_W  packed destination addresses; slice k = [k*RADDR_W +: RADDR_W].
- fwd_data  in  NFWD*XLEN  packed result data.
- fwd_pending  in  NFWD  source k result not yet available (load in EX, multi-cycle op).
- out_valid  out  1  ID/EX payload valid.
- out_ready  in  1  EX accepts the payload.
- out_pc, out_op1, out_op2  out  XLEN each  registered PC and resolved operands.
- out_ctrl  out  CTRL_W  registered control.
- stall_o  out  1  IF/ID must hold its instruction.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Operand resolution per rsX, combinational:
  - en=0: op1=0; op2=in_imm if in_use_imm else 0.
  - addr=0: operand=0, no hazard, regardless of sources.
  - Otherwise scan k=0..NFWD-1. The first k with fwd_valid[k] and fwd_addr[k]==addr wins.
  - If the winner has fwd_pending[k]=1, hazard for rsX.
  - If the winner has fwd_pending[k]=0, operand=fwd_data[k].
  - No winner: operand=rf data.
  - A pending younger match blocks an older ready match, which is never used.
- hazard = in_valid & (hazard_rs1 | hazard_rs2).
- in_ready = ~out_valid | out_ready.
- accept = in_valid & in_ready & ~hazard & ~flush.
- stall_o = ~flush & in_valid & (hazard | ~in_ready).
- Output register, priority order:
  - rst: out_valid=0; out_pc, out_op1, out_op2, out_ctrl=0.
  - flush: out_valid=0, payload unchanged.
  - in_ready: out_valid<=accept; payload loaded only on accept.
  - Otherwise hold everything.
- Hazard with in_ready=1 inserts a bubble (out_valid=0). Hazard with in_ready=0 holds the existing payload.
- stall_cnt: reset 0. Increments by 1 each cycle with hazard & ~flush. Holds at 2^CNT_W-1.

## Timing
- Latency: accept in cycle N gives out_valid=1 with the payload in cycle N+1.
- Throughput: one instruction per cycle when no hazard and out_ready=1.
- Payload stays stable while out_valid & ~out_ready.
- Operands sample forwarding and RF data in the accept cycle only. The held payload is never re-resolved.
- A load hazard clears the cycle fwd_pending drops or the producer moves to a non-pending slot. A single-cycle load costs exactly one bubble.
- Reset mid-stall: all outputs return to reset values the next cycle; stall_cnt=0.
- flush and hazard in the same cycle: stall_o=0, no count, out_valid=0.

## Test plan
- Back-to-back: rs1=x1 (RF=5), rs2 disabled, imm=7, use_imm=1, out_ready=1 for 4 cycles -> out_valid from cycle 1, op1=5, op2=7, one per cycle, stall_cnt=0.
- Priority: src0 {x3, 0xAA, ready}, src1 {x3, 0xBB, ready}, RF x3=0xCC -> op1=0xAA. With src0 invalid -> 0xBB.
- Load-use: src0 {x4, pending=1}, rs2=x4 -> stall_o=1, bubble, stall_cnt=1. Next cycle src1 {x4, 0x1234, ready} -> op2=0x1234, stall_o=0.
- x0: rs1=x0, src0 {x0, 0xFF, pending=1} -> op1=0, no stall.
- Backpressure: out_ready=0 for 3 cycles with new input -> in_ready=0, stall_o=1, payload stable, stall_cnt unchanged. Release -> next instruction appears one cycle later.
- Flush and saturation: flush with out_valid=1 -> out_valid=0 next cycle. CNT_W=2 with 5 hazard cycles -> stall_cnt holds at 3.
